// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32_pkg
// Description : Shared RV32I decode constants, immediate-type enum and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32_pkg;

    // Major opcodes, instr[6:2]
    localparam logic [4:0] c_opc_load   = 5'b00000;
    localparam logic [4:0] c_opc_op_imm = 5'b00100;
    localparam logic [4:0] c_opc_auipc  = 5'b00101;
    localparam logic [4:0] c_opc_store  = 5'b01000;
    localparam logic [4:0] c_opc_op     = 5'b01100;
    localparam logic [4:0] c_opc_lui    = 5'b01101;
    localparam logic [4:0] c_opc_branch = 5'b11000;
    localparam logic [4:0] c_opc_jalr   = 5'b11001;
    localparam logic [4:0] c_opc_jal    = 5'b11011;

    localparam logic [2:0] c_f3_add  = 3'b000;
    localparam logic [2:0] c_f3_sll  = 3'b001;
    localparam logic [2:0] c_f3_slt  = 3'b010;
    localparam logic [2:0] c_f3_sltu = 3'b011;
    localparam logic [2:0] c_f3_xor  = 3'b100;
    localparam logic [2:0] c_f3_sr   = 3'b101;
    localparam logic [2:0] c_f3_or   = 3'b110;
    localparam logic [2:0] c_f3_and  = 3'b111;

    localparam logic [2:0] c_f3_beq  = 3'b000;
    localparam logic [2:0] c_f3_bne  = 3'b001;
    localparam logic [2:0] c_f3_blt  = 3'b100;
    localparam logic [2:0] c_f3_bge  = 3'b101;
    localparam logic [2:0] c_f3_bltu = 3'b110;
    localparam logic [2:0] c_f3_bgeu = 3'b111;

    localparam logic [6:0] c_f7_base = 7'b0000000;
    localparam logic [6:0] c_f7_alt  = 7'b0100000;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_type_e;

    function automatic logic is_known_opcode(input logic [4:0] opc);
        return (opc == c_opc_load)  || (opc == c_opc_op_imm) || (opc == c_opc_auipc) ||
               (opc == c_opc_store) || (opc == c_opc_op)     || (opc == c_opc_lui)   ||
               (opc == c_opc_branch)|| (opc == c_opc_jalr)   || (opc == c_opc_jal);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv32_imm_gen.sv
`default_nettype none
// ============================================================================
// Module      : rv32_imm_gen
// Description : Combinational RV32I immediate generator (I/S/B/U/J formats).
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_imm_gen
    import rv32_pkg::*;
(
    input  logic [31:7] i_instr,
    input  imm_type_e   i_imm_type,
    output logic [31:0] o_imm
);

    always_comb begin
        o_imm = '0;
        case (i_imm_type)
            IMM_I: o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
            IMM_S: o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            IMM_B: o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                            i_instr[30:25], i_instr[11:8], 1'b0};
            IMM_U: o_imm = {i_instr[31:12], 12'b0};
            IMM_J: o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                            i_instr[20], i_instr[30:21], 1'b0};
            default: o_imm = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rv32_decode_issue.sv
`default_nettype none
// ============================================================================
// Module      : rv32_decode_issue
// Description : RV32I decode/issue stage with writeback bypass and a single
//               backpressured issue register. Optional RV32_ILLEGAL_DETECT_EN
//               adds illegal-instruction detection and the out_illegal port.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_decode_issue
    import rv32_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    output logic [4:0]        rs1_addr,
    output logic [4:0]        rs2_addr,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic              wb_we,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        out_opcode,
    output logic [2:0]        out_func3,
    output logic              out_func7,
    output logic [XLEN-1:0]   out_operand1,
    output logic [XLEN-1:0]   out_operand2,
    output logic [XLEN-1:0]   out_store_data,
    output logic [XLEN-1:0]   out_target,
    output logic [4:0]        out_rd,
    output logic              out_rd_we,
`ifdef RV32_ILLEGAL_DETECT_EN
    output logic              out_illegal,
`endif
    output logic [CNT_W-1:0]  issued_count
);

    logic [4:0]      w_opcode;
    logic [2:0]      w_func3;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_jalr_sum;
    imm_type_e       w_imm_type;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;
    logic [XLEN-1:0] w_store_data;
    logic [XLEN-1:0] w_target;
    logic            w_rd_we;
    logic            w_func7;
    logic            w_illegal;
    logic            w_accept;
    logic            w_xfer;

    assign w_opcode = in_instr[6:2];
    assign w_func3  = in_instr[14:12];
    assign w_rd     = in_instr[11:7];
    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];

    // x0 is hardwired; a same-cycle writeback overrides the stale regfile read
    assign w_rs1_val = (rs1_addr == 5'd0) ? '0 :
                       (wb_we && (wb_rd == rs1_addr)) ? wb_data : rs1_data;
    assign w_rs2_val = (rs2_addr == 5'd0) ? '0 :
                       (wb_we && (wb_rd == rs2_addr)) ? wb_data : rs2_data;

    assign in_ready = !out_valid || out_ready || flush;
    assign w_accept = in_valid && in_ready;
    assign w_xfer   = out_valid && out_ready && !flush;

    always_comb begin
        w_imm_type = IMM_I;
        case (w_opcode)
            c_opc_store:              w_imm_type = IMM_S;
            c_opc_branch:             w_imm_type = IMM_B;
            c_opc_lui, c_opc_auipc:   w_imm_type = IMM_U;
            c_opc_jal:                w_imm_type = IMM_J;
            default:                  w_imm_type = IMM_I;
        endcase
    end

    rv32_imm_gen u_imm_gen (
        .i_instr    (in_instr[31:7]),
        .i_imm_type (w_imm_type),
        .o_imm      (w_imm)
    );

    assign w_jalr_sum = w_rs1_val + w_imm;

`ifdef RV32_ILLEGAL_DETECT_EN
    always_comb begin
        w_illegal = (in_instr[1:0] != 2'b11) || !is_known_opcode(w_opcode);
        if (w_opcode == c_opc_op &&
            in_instr[31:25] != c_f7_base && in_instr[31:25] != c_f7_alt)
            w_illegal = 1'b1;
        if (w_opcode == c_opc_op_imm && w_func3 == c_f3_sll &&
            in_instr[31:25] != c_f7_base)
            w_illegal = 1'b1;
        if (w_opcode == c_opc_op_imm && w_func3 == c_f3_sr &&
            in_instr[31:25] != c_f7_base && in_instr[31:25] != c_f7_alt)
            w_illegal = 1'b1;
    end
`else
    assign w_illegal = 1'b0;
    logic w_unused_lsb;
    assign w_unused_lsb = &{1'b0, in_instr[1:0]};
`endif

    always_comb begin
        w_op1        = '0;
        w_op2        = '0;
        w_store_data = '0;
        w_target     = '0;
        w_rd_we      = 1'b0;
        w_func7      = 1'b0;
        case (w_opcode)
            c_opc_lui: begin
                w_op2   = w_imm;
                w_rd_we = 1'b1;
            end
            c_opc_auipc: begin
                w_op1   = in_pc;
                w_op2   = w_imm;
                w_rd_we = 1'b1;
            end
            c_opc_load: begin
                w_op1   = w_rs1_val;
                w_op2   = w_imm;
                w_rd_we = 1'b1;
            end
            c_opc_store: begin
                w_op1        = w_rs1_val;
                w_op2        = w_imm;
                w_store_data = w_rs2_val;
            end
            c_opc_jal: begin
                w_op1    = in_pc;
                w_target = in_pc + w_imm;
                w_rd_we  = 1'b1;
            end
            c_opc_jalr: begin
                w_op1    = in_pc;
                w_target = {w_jalr_sum[XLEN-1:1], 1'b0};
                w_rd_we  = 1'b1;
            end
            c_opc_branch: begin
                w_op1    = w_rs1_val;
                w_op2    = w_rs2_val;
                w_target = in_pc + w_imm;
            end
            c_opc_op_imm: begin
                w_op1   = w_rs1_val;
                w_op2   = w_imm;
                w_rd_we = 1'b1;
                // only shifts carry an alternate-form bit; addi imm[10] must not leak
                w_func7 = (w_func3 == c_f3_sr) ? in_instr[30] : 1'b0;
            end
            c_opc_op: begin
                w_op1   = w_rs1_val;
                w_op2   = w_rs2_val;
                w_rd_we = 1'b1;
                w_func7 = in_instr[30];
            end
            default: begin
                w_op1 = '0;
            end
        endcase
        if (w_illegal) begin
            w_op1   = '0;
            w_op2   = '0;
            w_rd_we = 1'b0;
        end
        if (w_rd == 5'd0)
            w_rd_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_opcode     <= '0;
            out_func3      <= '0;
            out_func7      <= 1'b0;
            out_operand1   <= '0;
            out_operand2   <= '0;
            out_store_data <= '0;
            out_target     <= '0;
            out_rd         <= '0;
            out_rd_we      <= 1'b0;
`ifdef RV32_ILLEGAL_DETECT_EN
            out_illegal    <= 1'b0;
`endif
            issued_count   <= '0;
        end else begin
            if (w_xfer)
                issued_count <= issued_count + CNT_W'(1);
            if (flush) begin
                out_valid <= 1'b0;
            end else if (w_accept) begin
                out_valid      <= 1'b1;
                out_opcode     <= w_opcode;
                out_func3      <= w_func3;
                out_func7      <= w_func7;
                out_operand1   <= w_op1;
                out_operand2   <= w_op2;
                out_store_data <= w_store_data;
                out_target     <= w_target;
                out_rd         <= w_rd;
                out_rd_we      <= w_rd_we;
`ifdef RV32_ILLEGAL_DETECT_EN
                out_illegal    <= w_illegal;
`endif
            end else if (w_xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv32_decode_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32_decode_issue
// Description : Directed self-checking bench for rv32_decode_issue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32_decode_issue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_opcode;
    logic [2:0]  out_func3;
    logic        out_func7;
    logic [31:0] out_operand1;
    logic [31:0] out_operand2;
    logic [31:0] out_store_data;
    logic [31:0] out_target;
    logic [4:0]  out_rd;
    logic        out_rd_we;
`ifdef RV32_ILLEGAL_DETECT_EN
    logic        out_illegal;
`endif
    logic [31:0] issued_count;

    int total = 0;
    int bad   = 0;

    rv32_decode_issue #(.XLEN(32), .CNT_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_instr       (in_instr),
        .in_pc          (in_pc),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .wb_we          (wb_we),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_opcode     (out_opcode),
        .out_func3      (out_func3),
        .out_func7      (out_func7),
        .out_operand1   (out_operand1),
        .out_operand2   (out_operand2),
        .out_store_data (out_store_data),
        .out_target     (out_target),
        .out_rd         (out_rd),
        .out_rd_we      (out_rd_we),
`ifdef RV32_ILLEGAL_DETECT_EN
        .out_illegal    (out_illegal),
`endif
        .issued_count   (issued_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        rs1_data = '0; rs2_data = '0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        flush = 1'b0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_count", issued_count, 32'h0);
        chk("rst_op2", out_operand2, 32'h0);
        chk("rst_rdwe", 32'(out_rd_we), 32'h0);
        rst = 1'b0;

        // addi x1,x2,5
        in_valid = 1'b1; in_instr = 32'h00510093; in_pc = 32'h100; rs1_data = 32'd7; rs2_data = '0;
        #1;
        chk("addi_rs1a", 32'(rs1_addr), 32'd2);
        chk("addi_rs2a", 32'(rs2_addr), 32'd5);
        chk("addi_inrdy", 32'(in_ready), 32'h1);
        tick();
        chk("addi_valid", 32'(out_valid), 32'h1);
        chk("addi_opc", 32'(out_opcode), 32'h04);
        chk("addi_f3", 32'(out_func3), 32'h0);
        chk("addi_f7", 32'(out_func7), 32'h0);
        chk("addi_op1", out_operand1, 32'd7);
        chk("addi_op2", out_operand2, 32'd5);
        chk("addi_rd", 32'(out_rd), 32'd1);
        chk("addi_rdwe", 32'(out_rd_we), 32'h1);
        chk("addi_cnt", issued_count, 32'd0);

        // sub x3,x1,x2 with x1 forwarded from writeback
        in_instr = 32'h402081B3; rs1_data = 32'h0; rs2_data = 32'd5;
        wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h20;
        tick();
        chk("sub_cnt", issued_count, 32'd1);
        chk("sub_opc", 32'(out_opcode), 32'h0C);
        chk("sub_op1_fwd", out_operand1, 32'h20);
        chk("sub_op2", out_operand2, 32'd5);
        chk("sub_f7", 32'(out_func7), 32'h1);
        chk("sub_rd", 32'(out_rd), 32'd3);
        chk("sub_rdwe", 32'(out_rd_we), 32'h1);
        wb_we = 1'b0;

        // srai x5,x6,3
        in_instr = 32'h40335293; rs1_data = 32'h80000000; rs2_data = '0;
        tick();
        chk("srai_cnt", issued_count, 32'd2);
        chk("srai_opc", 32'(out_opcode), 32'h04);
        chk("srai_f3", 32'(out_func3), 32'h5);
        chk("srai_f7", 32'(out_func7), 32'h1);
        chk("srai_op1", out_operand1, 32'h80000000);
        chk("srai_op2", out_operand2, 32'h403);

        // addi x1,x0,0x400: imm bit 10 lands on instr[30]; func7 stays 0, x0 reads 0
        in_instr = 32'h40000093; rs1_data = 32'hDEADBEEF;
        tick();
        chk("addi400_f7", 32'(out_func7), 32'h0);
        chk("addi400_op1_x0", out_operand1, 32'h0);
        chk("addi400_op2", out_operand2, 32'h400);

        // beq x1,x2,+8
        in_instr = 32'h00208463; in_pc = 32'h200; rs1_data = 32'h11; rs2_data = 32'h22;
        tick();
        chk("beq_opc", 32'(out_opcode), 32'h18);
        chk("beq_op1", out_operand1, 32'h11);
        chk("beq_op2", out_operand2, 32'h22);
        chk("beq_tgt", out_target, 32'h208);
        chk("beq_rdwe", 32'(out_rd_we), 32'h0);

        // lui x7,0x12345
        in_instr = 32'h123453B7;
        tick();
        chk("lui_opc", 32'(out_opcode), 32'h0D);
        chk("lui_op1", out_operand1, 32'h0);
        chk("lui_op2", out_operand2, 32'h12345000);
        chk("lui_rd", 32'(out_rd), 32'd7);
        chk("lui_rdwe", 32'(out_rd_we), 32'h1);

        // jal x1,+16
        in_instr = 32'h010000EF; in_pc = 32'h300;
        tick();
        chk("jal_op1", out_operand1, 32'h300);
        chk("jal_op2", out_operand2, 32'h0);
        chk("jal_tgt", out_target, 32'h310);
        chk("jal_rdwe", 32'(out_rd_we), 32'h1);

        // jalr x0,5(x2): odd target bit cleared, rd=x0 suppresses write
        in_instr = 32'h00510067; in_pc = 32'h400; rs1_data = 32'h101;
        tick();
        chk("jalr_op1", out_operand1, 32'h400);
        chk("jalr_tgt", out_target, 32'h106);
        chk("jalr_rdwe", 32'(out_rd_we), 32'h0);

        // sw x2,8(x1)
        in_instr = 32'h0020A423; rs1_data = 32'h1000; rs2_data = 32'hCAFE;
        tick();
        chk("sw_opc", 32'(out_opcode), 32'h08);
        chk("sw_op1", out_operand1, 32'h1000);
        chk("sw_op2", out_operand2, 32'h8);
        chk("sw_sdata", out_store_data, 32'hCAFE);
        chk("sw_rdwe", 32'(out_rd_we), 32'h0);

        // addi x1,x1,-1
        in_instr = 32'hFFF08093; rs1_data = 32'd3; rs2_data = '0;
        tick();
        chk("addineg_op2", out_operand2, 32'hFFFFFFFF);
        chk("addineg_cnt", issued_count, 32'd9);

        // backpressure: accept A, stall B for three cycles
        in_instr = 32'h00100093; rs1_data = '0;
        tick();
        chk("bp_a_op2", out_operand2, 32'd1);
        chk("bp_a_cnt", issued_count, 32'd10);
        out_ready = 1'b0; in_instr = 32'h00200093;
        #1;
        chk("bp_inrdy", 32'(in_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_valid", 32'(out_valid), 32'h1);
            chk("bp_hold_op2", out_operand2, 32'd1);
            chk("bp_hold_cnt", issued_count, 32'd10);
            chk("bp_hold_inrdy", 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rel_inrdy", 32'(in_ready), 32'h1);
        tick();
        chk("bp_b_op2", out_operand2, 32'd2);
        chk("bp_b_cnt", issued_count, 32'd11);
        in_valid = 1'b0;
        tick();
        chk("bp_drain_valid", 32'(out_valid), 32'h0);
        chk("bp_drain_cnt", issued_count, 32'd12);

        // flush with out_ready and a new input present
        in_valid = 1'b1; in_instr = 32'h00300093;
        tick();
        chk("fl_pre_valid", 32'(out_valid), 32'h1);
        chk("fl_pre_op2", out_operand2, 32'd3);
        flush = 1'b1; in_instr = 32'h00400093;
        #1;
        chk("fl_inrdy", 32'(in_ready), 32'h1);
        tick();
        chk("fl_valid", 32'(out_valid), 32'h0);
        chk("fl_cnt", issued_count, 32'd12);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("fl_dropped_valid", 32'(out_valid), 32'h0);
        chk("fl_dropped_cnt", issued_count, 32'd12);

        // reset mid-stream
        in_valid = 1'b1; in_instr = 32'h00500093; out_ready = 1'b0;
        tick();
        chk("mr_pre_valid", 32'(out_valid), 32'h1);
        chk("mr_pre_op2", out_operand2, 32'd5);
        rst = 1'b1;
        tick();
        chk("mr_valid", 32'(out_valid), 32'h0);
        chk("mr_op2", out_operand2, 32'h0);
        chk("mr_rd", 32'(out_rd), 32'h0);
        chk("mr_opc", 32'(out_opcode), 32'h0);
        chk("mr_cnt", issued_count, 32'h0);
        rst = 1'b0; in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
